// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard_track pipeline destination tracker.
package hazard_pkg;

    localparam int unsigned TNEW_W_DEF = 3;
    localparam int unsigned TNEW_W_MAX = 8;
    localparam int unsigned REG_W      = 5;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // One pipeline stage record; tnew is sized for the widest supported TNEW_W.
    typedef struct packed {
        logic [REG_W-1:0]      a3;
        logic [REG_W-1:0]      rs;
        logic [REG_W-1:0]      rt;
        logic                  reg_write;
        logic [TNEW_W_MAX-1:0] tnew;
    } stage_rec_t;

    localparam stage_rec_t BUBBLE = '{
        a3:        REG_ZERO,
        rs:        REG_ZERO,
        rt:        REG_ZERO,
        reg_write: 1'b0,
        tnew:      '0
    };

endpackage

// File: rtl/hazard_track_if.sv
// D-stage request and E/M/W tracking bus of hazard_track; stall statistics under STALL_STAT_EN.
interface hazard_track_if
    import hazard_pkg::*;
#(
    parameter int unsigned TNEW_W = TNEW_W_DEF
) ();

    logic              stall;
    logic [REG_W-1:0]  D_A3;
    logic [REG_W-1:0]  D_rs;
    logic [REG_W-1:0]  D_rt;
    logic              D_RegWrite;
    logic [TNEW_W-1:0] D_Tnew;

    logic [REG_W-1:0]  E_A3;
    logic [REG_W-1:0]  M_A3;
    logic [REG_W-1:0]  W_A3;
    logic [TNEW_W-1:0] E_Tnew;
    logic [TNEW_W-1:0] M_Tnew;
    logic [TNEW_W-1:0] W_Tnew;
    logic              E_RegWrite;
    logic              M_RegWrite;
    logic              W_RegWrite;
    logic [REG_W-1:0]  E_rs;
    logic [REG_W-1:0]  E_rt;
    logic [REG_W-1:0]  M_rt;
`ifdef STALL_STAT_EN
    logic [31:0]       stall_cnt;
    logic [7:0]        stall_max;
`endif

    modport master (
        output stall, D_A3, D_rs, D_rt, D_RegWrite, D_Tnew,
        input  E_A3, M_A3, W_A3, E_Tnew, M_Tnew, W_Tnew,
        input  E_RegWrite, M_RegWrite, W_RegWrite, E_rs, E_rt, M_rt
`ifdef STALL_STAT_EN
        , input stall_cnt, stall_max
`endif
    );

    modport slave (
        input  stall, D_A3, D_rs, D_rt, D_RegWrite, D_Tnew,
        output E_A3, M_A3, W_A3, E_Tnew, M_Tnew, W_Tnew,
        output E_RegWrite, M_RegWrite, W_RegWrite, E_rs, E_rt, M_rt
`ifdef STALL_STAT_EN
        , output stall_cnt, stall_max
`endif
    );

endinterface

// File: rtl/hz_stage_reg.sv
// One pipeline stage record: async reset, synchronous bubble load, optional Tnew decrement.
module hz_stage_reg
    import hazard_pkg::*;
#(
    parameter int unsigned TNEW_W  = TNEW_W_DEF,
    parameter bit          SAT_DEC = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bubble_i,
    input  logic       dec_i,
    input  stage_rec_t d_i,
    output stage_rec_t q_o
);

    localparam logic [TNEW_W_MAX-1:0] TNEW_MASK = TNEW_W_MAX'((64'd1 << TNEW_W) - 64'd1);

    stage_rec_t            q_d;
    stage_rec_t            q_q;
    logic [TNEW_W_MAX-1:0] tnew_dec;

    // Decrement wraps within TNEW_W bits unless saturation is selected.
    always_comb begin
        tnew_dec = (d_i.tnew - TNEW_W_MAX'(1)) & TNEW_MASK;
        if (SAT_DEC && (d_i.tnew == '0)) begin
            tnew_dec = '0;
        end
        q_d           = d_i;
        q_d.reg_write = d_i.reg_write && (d_i.a3 != REG_ZERO);
        if (dec_i) begin
            q_d.tnew = tnew_dec;
        end
        if (bubble_i) begin
            q_d = BUBBLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= BUBBLE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/hazard_track.sv
// E/M/W destination and Tnew tracker for the hazard unit.
// Optional stall statistics (stall_cnt, stall_max) are built when STALL_STAT_EN is defined.
module hazard_track
    import hazard_pkg::*;
#(
    parameter int unsigned TNEW_W  = TNEW_W_DEF,
    parameter bit          SAT_DEC = 1'b1
) (
    input logic           clk,
    input logic           reset,
    hazard_track_if.slave bus
);

    stage_rec_t d_rec;
    stage_rec_t e_q;
    stage_rec_t m_in;
    stage_rec_t m_q;
    stage_rec_t w_in;
    stage_rec_t w_q;

    // M keeps only rt of the source fields; W keeps none.
    always_comb begin
        d_rec = '{
            a3:        bus.D_A3,
            rs:        bus.D_rs,
            rt:        bus.D_rt,
            reg_write: bus.D_RegWrite,
            tnew:      TNEW_W_MAX'(bus.D_Tnew)
        };
        m_in    = e_q;
        m_in.rs = REG_ZERO;
        w_in    = m_q;
        w_in.rs = REG_ZERO;
        w_in.rt = REG_ZERO;
    end

    hz_stage_reg #(.TNEW_W(TNEW_W), .SAT_DEC(SAT_DEC)) u_stage_e (
        .clk(clk), .rst(reset), .bubble_i(bus.stall), .dec_i(1'b0), .d_i(d_rec), .q_o(e_q)
    );

    hz_stage_reg #(.TNEW_W(TNEW_W), .SAT_DEC(SAT_DEC)) u_stage_m (
        .clk(clk), .rst(reset), .bubble_i(1'b0), .dec_i(1'b1), .d_i(m_in), .q_o(m_q)
    );

    hz_stage_reg #(.TNEW_W(TNEW_W), .SAT_DEC(SAT_DEC)) u_stage_w (
        .clk(clk), .rst(reset), .bubble_i(1'b0), .dec_i(1'b1), .d_i(w_in), .q_o(w_q)
    );

    assign bus.E_A3       = e_q.a3;
    assign bus.M_A3       = m_q.a3;
    assign bus.W_A3       = w_q.a3;
    assign bus.E_Tnew     = TNEW_W'(e_q.tnew);
    assign bus.M_Tnew     = TNEW_W'(m_q.tnew);
    assign bus.W_Tnew     = TNEW_W'(w_q.tnew);
    assign bus.E_RegWrite = e_q.reg_write;
    assign bus.M_RegWrite = m_q.reg_write;
    assign bus.W_RegWrite = w_q.reg_write;
    assign bus.E_rs       = e_q.rs;
    assign bus.E_rt       = e_q.rt;
    assign bus.M_rt       = m_q.rt;

    // Record bits that never reach a port (always-zero sources, spare Tnew bits).
    logic [3*REG_W+3*TNEW_W_MAX-1:0] unused_bits;
    assign unused_bits = {m_q.rs, w_q.rs, w_q.rt, e_q.tnew, m_q.tnew, w_q.tnew};

`ifdef STALL_STAT_EN
    logic [31:0] stall_cnt_d;
    logic [31:0] stall_cnt_q;
    logic [7:0]  run_d;
    logic [7:0]  run_q;
    logic [7:0]  max_d;
    logic [7:0]  max_q;

    // Current stall run saturates at 255, so the recorded maximum does too.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        run_d       = '0;
        max_d       = max_q;
        if (bus.stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
            run_d       = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
            if (run_d > max_q) begin
                max_d = run_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            run_q       <= '0;
            max_q       <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            run_q       <= run_d;
            max_q       <= max_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.stall_max = max_q;
`endif

endmodule

// File: tb/tb_hazard_track.sv
// Scoreboard bench for hazard_track: saturating and wrapping instances driven in lockstep.
module tb_hazard_track;

    localparam int unsigned TW   = 3;
    localparam int          TMOD = 1 << TW;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    hazard_track_if #(.TNEW_W(TW)) bus_s ();
    hazard_track_if #(.TNEW_W(TW)) bus_w ();

    hazard_track #(.TNEW_W(TW), .SAT_DEC(1'b1)) u_dut_sat (
        .clk(clk), .reset(reset), .bus(bus_s.slave)
    );
    hazard_track #(.TNEW_W(TW), .SAT_DEC(1'b0)) u_dut_wrap (
        .clk(clk), .reset(reset), .bus(bus_w.slave)
    );

    typedef struct {
        int a3;
        int rs;
        int rt;
        int rw;
        int t_sat;
        int t_wrap;
    } stg_t;

    typedef struct {
        stg_t   e;
        stg_t   m;
        stg_t   w;
        longint cnt;
        int     mx;
    } exp_t;

    exp_t   exp_q[$];
    stg_t   me, mm, mw;
    longint m_cnt;
    int     m_run;
    int     m_mx;
    int     n_chk  = 0;
    int     n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int dec_sat(input int t);
        return (t > 0) ? t - 1 : 0;
    endfunction

    function automatic int dec_wrap(input int t);
        return (t + TMOD - 1) % TMOD;
    endfunction

    function automatic stg_t zero_stg();
        stg_t s;
        s = '{a3: 0, rs: 0, rt: 0, rw: 0, t_sat: 0, t_wrap: 0};
        return s;
    endfunction

    task automatic model_clear();
        me    = zero_stg();
        mm    = zero_stg();
        mw    = zero_stg();
        m_cnt = 0;
        m_run = 0;
        m_mx  = 0;
    endtask

    // Apply one D request, advance the model on the edge, queue the expected view.
    task automatic step(input bit st, input int a3, input int rs, input int rt,
                        input bit rw, input int t);
        bus_s.stall = st;        bus_w.stall = st;
        bus_s.D_A3 = 5'(a3);     bus_w.D_A3 = 5'(a3);
        bus_s.D_rs = 5'(rs);     bus_w.D_rs = 5'(rs);
        bus_s.D_rt = 5'(rt);     bus_w.D_rt = 5'(rt);
        bus_s.D_RegWrite = rw;   bus_w.D_RegWrite = rw;
        bus_s.D_Tnew = TW'(t);   bus_w.D_Tnew = TW'(t);
        @(posedge clk);
        mw = '{a3: mm.a3, rs: 0, rt: 0, rw: mm.rw,
               t_sat: dec_sat(mm.t_sat), t_wrap: dec_wrap(mm.t_wrap)};
        mm = '{a3: me.a3, rs: 0, rt: me.rt, rw: me.rw,
               t_sat: dec_sat(me.t_sat), t_wrap: dec_wrap(me.t_wrap)};
        if (st) me = zero_stg();
        else    me = '{a3: a3, rs: rs, rt: rt, rw: int'(rw && (a3 != 0)), t_sat: t, t_wrap: t};
        if (st) begin
            m_cnt = (m_cnt + 1) % (64'd1 << 32);
            m_run = (m_run < 255) ? m_run + 1 : 255;
            if (m_run > m_mx) m_mx = m_run;
        end else begin
            m_run = 0;
        end
        exp_q.push_back('{e: me, m: mm, w: mw, cnt: m_cnt, mx: m_mx});
        @(negedge clk);
    endtask

    task automatic chk_zero();
        chk("rst_E_A3",  64'(bus_s.E_A3), 0);   chk("rst_M_A3",  64'(bus_s.M_A3), 0);
        chk("rst_W_A3",  64'(bus_s.W_A3), 0);   chk("rst_E_Tnew", 64'(bus_s.E_Tnew), 0);
        chk("rst_M_Tnew", 64'(bus_s.M_Tnew), 0); chk("rst_W_Tnew", 64'(bus_s.W_Tnew), 0);
        chk("rst_E_RW",  64'(bus_s.E_RegWrite), 0); chk("rst_M_RW", 64'(bus_s.M_RegWrite), 0);
        chk("rst_W_RW",  64'(bus_s.W_RegWrite), 0); chk("rst_E_rs", 64'(bus_s.E_rs), 0);
        chk("rst_E_rt",  64'(bus_s.E_rt), 0);   chk("rst_M_rt",  64'(bus_s.M_rt), 0);
        chk("rst_wrap_M_Tnew", 64'(bus_w.M_Tnew), 0);
        chk("rst_wrap_W_Tnew", 64'(bus_w.W_Tnew), 0);
`ifdef STALL_STAT_EN
        chk("rst_stall_cnt", 64'(bus_s.stall_cnt), 0);
        chk("rst_stall_max", 64'(bus_s.stall_max), 0);
`endif
    endtask

    // Monitor: outputs are valid every cycle, so compare once per queued edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                chk("E_A3",   64'(bus_s.E_A3),       64'(x.e.a3));
                chk("E_rs",   64'(bus_s.E_rs),       64'(x.e.rs));
                chk("E_rt",   64'(bus_s.E_rt),       64'(x.e.rt));
                chk("E_RW",   64'(bus_s.E_RegWrite), 64'(x.e.rw));
                chk("E_Tnew", 64'(bus_s.E_Tnew),     64'(x.e.t_sat));
                chk("M_A3",   64'(bus_s.M_A3),       64'(x.m.a3));
                chk("M_rt",   64'(bus_s.M_rt),       64'(x.m.rt));
                chk("M_RW",   64'(bus_s.M_RegWrite), 64'(x.m.rw));
                chk("M_Tnew_sat",  64'(bus_s.M_Tnew), 64'(x.m.t_sat));
                chk("M_Tnew_wrap", 64'(bus_w.M_Tnew), 64'(x.m.t_wrap));
                chk("W_A3",   64'(bus_s.W_A3),       64'(x.w.a3));
                chk("W_RW",   64'(bus_s.W_RegWrite), 64'(x.w.rw));
                chk("W_Tnew_sat",  64'(bus_s.W_Tnew), 64'(x.w.t_sat));
                chk("W_Tnew_wrap", 64'(bus_w.W_Tnew), 64'(x.w.t_wrap));
                chk("wrap_E_A3", 64'(bus_w.E_A3),    64'(x.e.a3));
`ifdef STALL_STAT_EN
                chk("stall_cnt", 64'(bus_s.stall_cnt), 64'(x.cnt));
                chk("stall_max", 64'(bus_s.stall_max), 64'(x.mx));
`endif
            end
        end
    end

    initial begin
        model_clear();
        bus_s.stall = 1'b0; bus_s.D_A3 = '0; bus_s.D_rs = '0; bus_s.D_rt = '0;
        bus_s.D_RegWrite = 1'b0; bus_s.D_Tnew = '0;
        bus_w.stall = 1'b0; bus_w.D_A3 = '0; bus_w.D_rs = '0; bus_w.D_rt = '0;
        bus_w.D_RegWrite = 1'b0; bus_w.D_Tnew = '0;
        #2;
        chk_zero();
        @(negedge clk);
        reset = 1'b0;

        // lw $8 walks E, M, W with Tnew 2, 1, 0
        step(0, 8, 1, 2, 1, 2);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("lw_W_A3",   64'(bus_s.W_A3), 8);
        chk("lw_W_Tnew", 64'(bus_s.W_Tnew), 0);

        // two stall cycles then the held instruction enters E
        step(1, 9, 3, 4, 1, 3);
        step(1, 9, 3, 4, 1, 3);
        chk("stall_bubble_E_A3", 64'(bus_s.E_A3), 0);
        step(0, 9, 3, 4, 1, 3);
        chk("stall_release_E_A3", 64'(bus_s.E_A3), 9);

        // write to $0 is never reported as a write
        step(0, 0, 3, 4, 1, 5);
        chk("zero_E_RW", 64'(bus_s.E_RegWrite), 0);

        // Tnew 0 entering M: saturate vs wrap
        step(0, 5, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("tnew0_M_sat",  64'(bus_s.M_Tnew), 0);
        chk("tnew0_M_wrap", 64'(bus_w.M_Tnew), 7);

        // asynchronous reset between edges
        #2;
        reset = 1'b1;
        #1;
        chk_zero();
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(0, 12, 3, 4, 1, 1);
        chk("post_rst_E_A3", 64'(bus_s.E_A3), 12);

        // stall pattern 1,1,1,0,1,1
        step(1, 7, 0, 0, 1, 1);
        step(1, 7, 0, 0, 1, 1);
        step(1, 7, 0, 0, 1, 1);
        step(0, 7, 0, 0, 1, 1);
        step(1, 6, 0, 0, 1, 2);
        step(1, 6, 0, 0, 1, 2);
`ifdef STALL_STAT_EN
        chk("pattern_stall_cnt", 64'(bus_s.stall_cnt), 5);
        chk("pattern_stall_max", 64'(bus_s.stall_max), 3);
`endif

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 3), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, TMOD - 1)));
        end

        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
